// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM round-robin arbiter.
package sdram_arb_pkg;

  localparam int ARB_ADDR_W = 26;
  localparam int ARB_DATA_W = 16;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ISSUE   = 3'd1,
    ARB_WAIT_RD = 3'd2,
    ARB_WR_HOLD = 3'd3,
    ARB_WAIT_WR = 3'd4
  } arb_state_t;

  // Width of an index able to name any of n requesters (at least one bit).
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, wrapping modulo N.
// Purely combinational so other arbiters can reuse it.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] win
);

  int unsigned idx;

  // Scan offsets from the highest down so the lowest offset from ptr wins last.
  always_comb begin
    any = 1'b0;
    win = {W{1'b0}};
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        any = 1'b1;
        win = W'(idx);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM word port between N_REQ requesters.
// One transaction outstanding at a time; held request levels become single
// command pulses and completions are routed back to the owning requester.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a transaction that has
// not completed TIMEOUT_CYC cycles after entering ISSUE (pulses o_err).
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_we,
  input  logic [N_REQ*ADDR_W-1:0]  i_addr,
  input  logic [N_REQ*DATA_W-1:0]  i_wdata,
  output logic [N_REQ-1:0]         o_ack,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [N_REQ-1:0]         o_rvalid,
  output logic [N_REQ-1:0]         o_wdone,
  output logic [N_REQ-1:0]         o_err,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  output logic                     o_mem_write,
  output logic                     o_mem_read,
  input  logic                     i_mem_ready,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  input  logic                     i_mem_rvalid
);

  localparam int OW = owner_w(N_REQ);

  arb_state_t         state_r;
  logic [OW-1:0]      ptr_r;
  logic [OW-1:0]      owner_r;
  logic               we_r;

  logic               pick_any_s;
  logic [OW-1:0]      pick_win_s;
  logic [OW-1:0]      next_ptr_s;
  logic [N_REQ-1:0]   win_oh_s;
  logic [N_REQ-1:0]   owner_oh_s;
  logic               win_we_s;
  logic [ADDR_W-1:0]  win_addr_s;
  logic [DATA_W-1:0]  win_wdata_s;
  logic               timeout_s;

  rr_pick #(.N(N_REQ), .W(OW)) u_pick (
    .req (i_req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .win (pick_win_s)
  );

  // Winner's request fields and one-hot masks for the winner and the current owner.
  always_comb begin
    win_we_s    = i_we[pick_win_s];
    win_addr_s  = i_addr[int'(pick_win_s) * ADDR_W +: ADDR_W];
    win_wdata_s = i_wdata[int'(pick_win_s) * DATA_W +: DATA_W];
    win_oh_s    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_win_s;
    owner_oh_s  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_r;
  end

  // Pointer value after the owner finishes: owner + 1, wrapping at N_REQ.
  always_comb begin
    if (owner_r == OW'(N_REQ - 1)) begin
      next_ptr_s = {OW{1'b0}};
    end else begin
      next_ptr_s = owner_r + OW'(1);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_r;

  // Watchdog age of the current transaction; zero in IDLE so ISSUE starts at 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ARB_IDLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Fire in the cycle the count would reach the limit so o_err lands exactly
  // TIMEOUT_CYC cycles after ISSUE entry.
  assign timeout_s = ((cnt_r + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC));
`else
  // No watchdog: constant false for any legal TIMEOUT_CYC, so o_err stays 0.
  assign timeout_s = (TIMEOUT_CYC < 0);
`endif

  // Arbitration FSM: grant, command issue, completion routing, registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ARB_IDLE;
      ptr_r       <= {OW{1'b0}};
      owner_r     <= {OW{1'b0}};
      we_r        <= 1'b0;
      o_ack       <= {N_REQ{1'b0}};
      o_rvalid    <= {N_REQ{1'b0}};
      o_wdone     <= {N_REQ{1'b0}};
      o_err       <= {N_REQ{1'b0}};
      o_rdata     <= {DATA_W{1'b0}};
      o_mem_addr  <= {ADDR_W{1'b0}};
      o_mem_wdata <= {DATA_W{1'b0}};
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
    end else begin
      o_ack       <= {N_REQ{1'b0}};
      o_rvalid    <= {N_REQ{1'b0}};
      o_wdone     <= {N_REQ{1'b0}};
      o_err       <= {N_REQ{1'b0}};
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (pick_any_s) begin
            owner_r     <= pick_win_s;
            we_r        <= win_we_s;
            o_mem_addr  <= win_addr_s;
            o_mem_wdata <= win_wdata_s;
            o_ack       <= win_oh_s;
            state_r     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (timeout_s) begin
            o_err   <= owner_oh_s;
            ptr_r   <= next_ptr_s;
            state_r <= ARB_IDLE;
          end else if (i_mem_ready) begin
            if (we_r) begin
              o_mem_write <= 1'b1;
              state_r     <= ARB_WR_HOLD;
            end else begin
              o_mem_read  <= 1'b1;
              state_r     <= ARB_WAIT_RD;
            end
          end
        end
        ARB_WAIT_RD: begin
          if (i_mem_rvalid) begin
            o_rdata  <= i_mem_rdata;
            o_rvalid <= owner_oh_s;
            ptr_r    <= next_ptr_s;
            state_r  <= ARB_IDLE;
          end else if (timeout_s) begin
            o_err   <= owner_oh_s;
            ptr_r   <= next_ptr_s;
            state_r <= ARB_IDLE;
          end
        end
        ARB_WR_HOLD: begin
          // Ready may still show the pre-command idle level here; skip it.
          if (timeout_s) begin
            o_err   <= owner_oh_s;
            ptr_r   <= next_ptr_s;
            state_r <= ARB_IDLE;
          end else begin
            state_r <= ARB_WAIT_WR;
          end
        end
        ARB_WAIT_WR: begin
          if (i_mem_ready) begin
            o_wdone <= owner_oh_s;
            ptr_r   <= next_ptr_s;
            state_r <= ARB_IDLE;
          end else if (timeout_s) begin
            o_err   <= owner_oh_s;
            ptr_r   <= next_ptr_s;
            state_r <= ARB_IDLE;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Self-checking bench for sdram_rr_arbiter: directed scenarios with literal
// expectations plus randomized requesters/memory against a transaction model.
module tb_sdram_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 26;
  localparam int DW = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    o_ack, o_rvalid, o_wdone, o_err;
  logic [DW-1:0]   o_rdata, o_mem_wdata, mem_rdata;
  logic [AW-1:0]   o_mem_addr;
  logic            o_mem_write, o_mem_read, mem_ready, mem_rvalid;

  always #5 clk = ~clk;

  sdram_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(o_ack), .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_wdone(o_wdone), .o_err(o_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_write(o_mem_write),
    .o_mem_read(o_mem_read), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .i_mem_rvalid(mem_rvalid)
  );

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  int ack_q[$];
  int wdone_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            t_busy, t_we, t_sent, t_guard, t_done;
  int            t_own, t_age, m_ptr, m_w;
  logic [N-1:0]  x_ack, x_rvalid, x_wdone, x_err;
  logic          x_rd, x_wr;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rdata;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    x_ack = '0; x_rvalid = '0; x_wdone = '0; x_err = '0; x_rd = 1'b0; x_wr = 1'b0;
    if (rst) begin
      t_busy = 1'b0; m_ptr = 0; x_addr = '0; x_wdata = '0; x_rdata = '0;
    end else if (!t_busy) begin
      m_w = pick(req, m_ptr);
      if (m_w >= 0) begin
        t_busy = 1'b1; t_own = m_w; t_we = we[m_w]; t_sent = 1'b0; t_guard = 1'b0; t_age = 0;
        x_addr  = addr[m_w*AW +: AW];
        x_wdata = wdata[m_w*DW +: DW];
        x_ack[m_w] = 1'b1;
      end
    end else begin
      t_done = 1'b0;
      if (t_sent && !t_we && mem_rvalid) begin
        x_rdata = mem_rdata; x_rvalid[t_own] = 1'b1; t_done = 1'b1;
      end else if (t_sent && t_we && t_guard && mem_ready) begin
        x_wdone[t_own] = 1'b1; t_done = 1'b1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (t_age + 1 == TO) begin
        x_err[t_own] = 1'b1; t_done = 1'b1;
      end
`endif
      else if (!t_sent && mem_ready) begin
        t_sent = 1'b1;
        if (t_we) x_wr = 1'b1; else x_rd = 1'b1;
      end else if (t_sent && t_we) begin
        t_guard = 1'b1;
      end
      t_age++;
      if (t_done) begin
        t_busy = 1'b0; m_ptr = (t_own + 1) % N;
      end
    end
  end

  // Compare every cycle away from the active edge and log grant/write order.
  always @(negedge clk) begin
    if (armed) begin
      chk("ack", o_ack, x_ack);
      chk("rvalid", o_rvalid, x_rvalid);
      chk("wdone", o_wdone, x_wdone);
      chk("err", o_err, x_err);
      chk("mem_read", o_mem_read, x_rd);
      chk("mem_write", o_mem_write, x_wr);
      chk("mem_addr", o_mem_addr, x_addr);
      chk("mem_wdata", o_mem_wdata, x_wdata);
      chk("rdata", o_rdata, x_rdata);
      for (int k = 0; k < N; k++) begin
        if (o_ack[k])   ack_q.push_back(k);
        if (o_wdone[k]) wdone_q.push_back(k);
      end
    end
  end

  // ---------------- randomized memory and requesters ----------------
  int lat_min = 1, lat_max = 3, spur_pct = 0, rdylow_pct = 0, keep_pct = 50, raise_pct = 30;
  bit mem_busy = 1'b0, mem_isrd = 1'b0;
  int mem_cnt = 0;

  task automatic mem_step();
    mem_rvalid = 1'b0;
    if (o_mem_read || o_mem_write) begin
      mem_busy = 1'b1; mem_isrd = o_mem_read; mem_ready = 1'b0;
      mem_cnt = $urandom_range(lat_max, lat_min);
    end else if (mem_busy) begin
      if (mem_cnt > 0) mem_cnt--;
      if (mem_cnt == 0) begin
        mem_busy = 1'b0; mem_ready = 1'b1;
        if (mem_isrd) begin
          mem_rvalid = 1'b1; mem_rdata = DW'($urandom);
        end
      end
    end else begin
      mem_ready = ($urandom_range(99, 0) >= rdylow_pct);
      if ($urandom_range(99, 0) < spur_pct) begin
        mem_rvalid = 1'b1; mem_rdata = DW'($urandom);
      end
    end
  endtask

  task automatic new_txn(input int k);
    req[k] = 1'b1;
    we[k]  = 1'($urandom);
    addr[k*AW +: AW]  = AW'($urandom);
    wdata[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic req_step();
    for (int k = 0; k < N; k++) begin
      if (o_ack[k]) begin
        if ($urandom_range(99, 0) < keep_pct) new_txn(k); else req[k] = 1'b0;
      end else if (!req[k]) begin
        if ($urandom_range(99, 0) < raise_pct) new_txn(k);
      end else if ($urandom_range(99, 0) < 2) begin
        req[k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    req = '0; mem_ready = 1'b1; mem_rvalid = 1'b0; mem_busy = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    tick(); tick();
    armed = 1'b1;
    chk("rst_ack", o_ack, 3'b000);
    chk("rst_mem_read", o_mem_read, 1'b0);
    chk("rst_mem_addr", o_mem_addr, 26'h0);
    rst = 1'b0;

    // Single read: ack at N+1, read command at N+2, rvalid one cycle after data.
    mem_ready = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0 +: AW] = 26'h0000123;
    tick(); chk("rd_ack", o_ack, 3'b001); chk("rd_no_cmd_yet", o_mem_read, 1'b0); req[0] = 1'b0;
    tick(); chk("rd_cmd", o_mem_read, 1'b1); chk("rd_addr", o_mem_addr, 26'h0000123); mem_ready = 1'b0;
    tick(); chk("rd_cmd_pulse", o_mem_read, 1'b0);
    tick(); tick(); mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    chk("rd_not_early", o_rvalid, 3'b000);
    tick(); mem_rvalid = 1'b0; mem_ready = 1'b1;
    chk("rd_rvalid", o_rvalid, 3'b001); chk("rd_data", o_rdata, 16'hBEEF);

    // Contention: two writes raised together with ptr=0 -> served 0 then 1.
    do_reset();
    wdone_q.delete();
    lat_min = 2; lat_max = 2; spur_pct = 0; rdylow_pct = 0;
    req[1:0] = 2'b11; we[1:0] = 2'b11;
    addr[0 +: AW] = 26'h100; wdata[0 +: DW] = 16'h1111;
    addr[AW +: AW] = 26'h200; wdata[DW +: DW] = 16'h2222;
    for (int i = 0; i < 60 && wdone_q.size() < 2; i++) begin
      tick(); mem_step();
      for (int k = 0; k < 2; k++) if (o_ack[k]) req[k] = 1'b0;
    end
    chk("cont_cnt", wdone_q.size(), 2);
    chk("cont_first", (wdone_q.size() > 0) ? wdone_q[0] : 99, 0);
    chk("cont_second", (wdone_q.size() > 1) ? wdone_q[1] : 99, 1);

    // Both held: strict alternation 0,1,0,1.
    do_reset();
    wdone_q.delete();
    req[1:0] = 2'b11;
    for (int i = 0; i < 120 && wdone_q.size() < 4; i++) begin
      tick(); mem_step();
      for (int k = 0; k < 2; k++) if (o_ack[k]) addr[k*AW +: AW] = AW'($urandom);
    end
    for (int j = 0; j < 4; j++) chk("alternate", (wdone_q.size() > j) ? wdone_q[j] : 99, j % 2);

    // Back-pressure on requester 2 write, with spurious rvalid in ISSUE and WAIT_WR.
    do_reset();
    mem_ready = 1'b0; req[2] = 1'b1; we[2] = 1'b1;
    addr[2*AW +: AW] = 26'h3ABCDE; wdata[2*DW +: DW] = 16'hA55A;
    tick(); chk("bp_ack", o_ack, 3'b100); req[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_rvalid = (i == 3);
      tick();
      chk("bp_no_write", o_mem_write, 1'b0);
      chk("bp_no_rvalid", o_rvalid, 3'b000);
    end
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    tick(); chk("bp_write", o_mem_write, 1'b1);
    chk("bp_addr", o_mem_addr, 26'h3ABCDE); chk("bp_wdata", o_mem_wdata, 16'hA55A);
    tick(); chk("bp_stale_ready", o_wdone, 3'b000); chk("bp_one_pulse", o_mem_write, 1'b0);
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    tick(); mem_rvalid = 1'b0; chk("bp_spur", o_rvalid, 3'b000);
    mem_ready = 1'b1;
    tick(); chk("bp_wdone", o_wdone, 3'b100);
    tick();

    // Reset while waiting for read data; late rvalid ignored; req1 granted first.
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0; addr[0 +: AW] = 26'h0000456;
    tick(); chk("rr_ack0", o_ack, 3'b001); req[0] = 1'b0;
    tick(); chk("rr_cmd", o_mem_read, 1'b1); mem_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rr_z_ack", o_ack, 3'b000); chk("rr_z_rvalid", o_rvalid, 3'b000);
    chk("rr_z_addr", o_mem_addr, 26'h0); chk("rr_z_rdata", o_rdata, 16'h0);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    tick(); mem_rvalid = 1'b0; chk("rr_late", o_rvalid, 3'b000);
    req[1] = 1'b1; we[1] = 1'b0; addr[AW +: AW] = 26'h0000789; mem_ready = 1'b1;
    tick(); chk("rr_ack1", o_ack, 3'b010); req[1] = 1'b0;
    tick(); chk("rr_addr1", o_mem_addr, 26'h0000789);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    tick(); mem_rvalid = 1'b0; mem_ready = 1'b1;
    chk("rr_rvalid1", o_rvalid, 3'b010); chk("rr_data1", o_rdata, 16'h1234);

`ifdef ARB_TIMEOUT_EN
    // Unanswered read: o_err exactly TO cycles after ISSUE entry, then req1 served.
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0;
    tick(); chk("to_ack", o_ack, 3'b001); req[0] = 1'b0; req[1] = 1'b1; we[1] = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (o_mem_read) mem_ready = 1'b0;
      chk("to_early", o_err, 3'b000);
    end
    tick(); chk("to_err", o_err, 3'b001);
    tick(); chk("to_next", o_ack, 3'b010);
    req[1] = 1'b0;
`endif

    // Randomized traffic in three regimes, with occasional resets.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: begin lat_min = 1; lat_max = 3; spur_pct = 5;  rdylow_pct = 10; keep_pct = 70;  raise_pct = 30;  end
        1: begin lat_min = 1; lat_max = 8; spur_pct = 10; rdylow_pct = 40; keep_pct = 20;  raise_pct = 10;  end
        default: begin lat_min = 1; lat_max = 2; spur_pct = 0; rdylow_pct = 0; keep_pct = 100; raise_pct = 100; end
      endcase
      for (int c = 0; c < 800; c++) begin
        tick(); mem_step(); req_step();
        rst = ($urandom_range(499, 0) == 0);
      end
    end
    rst = 1'b0; req = '0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_rr_arbiter.md
Name: sdram_rr_arbiter

Overview:
Shares the single SDRAM 16-bit word-access port between N_REQ requesters, e.g. audio recorder, player and debug reader. Arbitration is round-robin, with one transaction outstanding at a time. The block sits between the requester blocks and the SDRAM word wrapper. It converts held-level requests into single-cycle read/write command pulses and routes each completion back to the owning requester.

Parameters:
N_REQ, 2, number of requesters; legal range 2..8
ADDR_W, 26, word address width
DATA_W, 16, data width
TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  N_REQ  per-requester request level; held until o_ack
i_we  in  N_REQ  per-requester 1=write, 0=read; stable while i_req is high
i_addr  in  N_REQ*ADDR_W  per-requester address, packed with requester k at [k*ADDR_W +: ADDR_W]
i_wdata  in  N_REQ*DATA_W  per-requester write data, packed the same way
o_ack  out  N_REQ  one-cycle pulse: request latched; requester may change or drop it
o_rdata  out  DATA_W  read data, shared by all requesters, qualified by o_rvalid
o_rvalid  out  N_REQ  one-cycle pulse to the read owner
o_wdone  out  N_REQ  one-cycle pulse to the write owner
o_err  out  N_REQ  one-cycle timeout pulse to the owner; constant 0 without the macro
o_mem_addr  out  ADDR_W  latched address
o_mem_wdata  out  DATA_W  latched write data
o_mem_write  out  1  one-cycle write command pulse
o_mem_read  out  1  one-cycle read command pulse
i_mem_ready  in  1  memory idle and able to accept a command; drops no later than 1 cycle after a command
i_mem_rdata  in  DATA_W  memory read data
i_mem_rvalid  in  1  memory read data valid

Behaviour:
- The clock and reset are decided: one clock; reset is synchronous and active-high (i_clk, i_rst).
- All outputs are registered. Reset value of every output is 0; state=IDLE; rr pointer=0.
- Reset mid-transaction drops the operation. No ack, rvalid, wdone or err pulse follows the reset.
- States: IDLE, ISSUE, WAIT_RD, WR_HOLD, WAIT_WR.
- IDLE:
  - If any i_req is high, the winner is the first set bit searching from ptr upward, wrapping modulo N_REQ.
  - Latch the winner's addr/wdata/we and the owner index. Pulse o_ack[win] in the next cycle. Go to ISSUE.
- ISSUE:
  - Wait for i_mem_ready=1.
  - Then pulse o_mem_read or o_mem_write for exactly 1 cycle (the next cycle).
  - Go to WAIT_RD for a read, WR_HOLD for a write.
  - o_mem_addr and o_mem_wdata hold their value from the latch until the next grant.
- WAIT_RD: on i_mem_rvalid, register o_rdata and pulse o_rvalid[owner] in the next cycle. Set ptr=owner+1 mod N_REQ. Go to IDLE.
- WR_HOLD: one-cycle guard so the stale i_mem_ready is ignored. Go to WAIT_WR.
- WAIT_WR: on i_mem_ready=1, pulse o_wdone[owner], set ptr=owner+1 mod N_REQ, go to IDLE.
- i_mem_rvalid outside WAIT_RD is ignored and produces no pulse.
- Latency:
  - i_req is sampled at cycle N (memory ready) -> o_ack at N+1 -> o_mem_read at N+2.
  - i_mem_rvalid at cycle M -> o_rvalid at M+1.
  - The next command issues no earlier than M+3.
- Fairness:
  - A lone requester holding i_req gets back-to-back service.
  - With K active requesters, each is served within K transactions.
- Requests are sampled only in IDLE. A requester that drops i_req before its o_ack simply is not served.
- No requester ever receives more than one pending grant.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments in ISSUE, WAIT_RD, WR_HOLD and WAIT_WR.
  - On reaching TIMEOUT_CYC: pulse o_err[owner], set ptr=owner+1 mod N_REQ, go to IDLE.
  - No rvalid or wdone pulse is produced for the timed-out transaction.
  - The counter width is $clog2(TIMEOUT_CYC+1).
- Undefined: no counter is built, the block waits indefinitely, and o_err is tied to 0.

Decomposition:
- Package sdram_arb_pkg: state enum type arb_state_t, default ADDR_W and DATA_W constants, and an owner-index width function.
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs any flag and winner index. Reusable by other arbiters.

Test Plan:
- Single read: N_REQ=2, req0 reads addr 0x0000123 with memory returning 0xBEEF after 3 cycles -> o_ack[0] at N+1, o_mem_read at N+2, o_rdata=0xBEEF with o_rvalid[0] one cycle after i_mem_rvalid.
- Contention: req0 and req1 writes raised in the same cycle with ptr=0 -> order req0 then req1; o_wdone[0] then o_wdone[1]. Repeat with both held -> strict alternation 0,1,0,1.
- Back-pressure: i_mem_ready held low 10 cycles after the grant -> o_mem_write asserts only after ready rises, as exactly one pulse, with addr/wdata unchanged.
- Spurious i_mem_rvalid during ISSUE or WAIT_WR -> no o_rvalid pulse; the write still completes with o_wdone.
- Reset asserted while in WAIT_RD -> all outputs 0 the next cycle. A later i_mem_rvalid produces no pulse. A subsequent req1 is granted first (ptr=0, only req1 active).
- ARB_TIMEOUT_EN with TIMEOUT_CYC=8 and a read never answered -> o_err[owner] pulses 8 cycles after ISSUE entry, the FSM returns to IDLE, and the next requester is served.
